adc_capture_ctrl: RTL

Sequencing controller for the 12-bit parallel ADC front end. It divides the system clock into the converter's sample clock and qualifies one signed sample per sample period. It arms on a software start, waits for a level-crossing trigger (with auto-trigger timeout), then writes a block of samples into an external single-port capture RAM. It sits between the register/control logic and the ADC receive stage.

---
 rtl/adc_capture_ctrl.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: sequencing controller for the 12-bit parallel ADC front end.
// Divides clk into the converter sample clock, qualifies one signed sample per
// sample period, arms on start, waits for a level-crossing trigger (or the
// auto-trigger timeout), then writes a block of samples into a single-port RAM.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   start, abort      one-cycle control pulses (abort wins over start)
//   div               sample period in clk cycles (values < 2 act as 2)
//   depth             block length; 0 means 2^ADDR_W samples
//   trig_mode         0/3 immediate, 1 rising crossing, 2 falling crossing
//   trig_level        signed trigger threshold
//   timeout           samples to wait in ARM before forcing a trigger; 0 disables
//   adc_data_s        signed sample from the ADC receive stage
//   adc_clk           sample clock to the converter
//   wr_en/addr/data   capture RAM write port (one-cycle write strobe)
//   busy, done        acquisition in progress / one-cycle completion pulse
//   forced            last acquisition was auto-triggered (held until next start)
module adc_capture_ctrl #(
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned TMO_W  = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [DIV_W-1:0]         div,
  input  logic [ADDR_W-1:0]        depth,
  input  logic [1:0]               trig_mode,
  input  logic signed [11:0]       trig_level,
  input  logic [TMO_W-1:0]         timeout,
  input  logic signed [11:0]       adc_data_s,
  output logic                     adc_clk,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic signed [11:0]       wr_data,
  output logic                     busy,
  output logic                     done,
  output logic                     forced
);

  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;

  // Divider and latched configuration
  logic [DIV_W-1:0]          r_cnt;
  logic [DIV_W-1:0]          r_d;
  logic [DIV_W-1:0]          r_div_lat;
  logic [ADDR_W-1:0]         r_depth;
  logic [1:0]                r_mode;
  logic signed [11:0]        r_level;
  logic [TMO_W-1:0]          r_tmo;

  // Acquisition state
  logic signed [11:0]        r_cur;
  logic [ADDR_W-1:0]         r_addr;
  logic [TMO_W-1:0]          r_tcnt;
  logic                      r_first;

  // Registered outputs
  logic                      r_adc_clk;
  logic                      r_wr_en;
  logic [ADDR_W-1:0]         r_wr_addr;
  logic signed [11:0]        r_wr_data;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_forced;

  logic                      w_s_stb;
  logic [DIV_W-1:0]          w_cnt_nxt;
  logic [DIV_W-1:0]          w_d_nxt;
  logic                      w_start_acc;
  logic                      w_rise;
  logic                      w_fall;
  logic                      w_hit;
  logic                      w_tmo_hit;
  logic                      w_last;
  logic [TMO_W-1:0]          w_tcnt_inc;
  logic                      w_wr_fire;
  logic                      w_done_nxt;
  logic                      w_forced_nxt;
  logic                      w_first_nxt;
  logic [ADDR_W-1:0]         w_addr_nxt;
  logic [TMO_W-1:0]          w_tcnt_nxt;

  // Free-running divider; a newly latched period is adopted only at the wrap
  assign w_s_stb = (r_cnt == (r_d - DIV_W'(1)));

  always_comb begin
    w_cnt_nxt = r_cnt + DIV_W'(1);
    w_d_nxt   = r_d;
    if (w_s_stb) begin
      w_cnt_nxt = '0;
      w_d_nxt   = r_div_lat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_d       <= DIV_MIN;
      r_adc_clk <= 1'b1;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_d       <= w_d_nxt;
      r_adc_clk <= (w_cnt_nxt < (w_d_nxt >> 1));
    end
  end

  assign w_start_acc = (r_state == S_IDLE) && start && !abort;

  // Configuration latched on an accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_lat <= DIV_MIN;
      r_depth   <= '0;
      r_mode    <= 2'd0;
      r_level   <= '0;
      r_tmo     <= '0;
    end else if (w_start_acc) begin
      r_div_lat <= (div < DIV_MIN) ? DIV_MIN : div;
      r_depth   <= depth;
      r_mode    <= trig_mode;
      r_level   <= trig_level;
      r_tmo     <= timeout;
    end
  end

  // Crossing is judged on the pair (previous sample, sample arriving on this strobe)
  assign w_rise     = (r_cur < r_level) && (adc_data_s >= r_level);
  assign w_fall     = (r_cur > r_level) && (adc_data_s <= r_level);
  assign w_tcnt_inc = r_tcnt + TMO_W'(1);
  assign w_tmo_hit  = (r_tmo != '0) && (w_tcnt_inc == r_tmo);
  // depth 0 wraps to all-ones, giving a full 2^ADDR_W block
  assign w_last     = (r_addr == (r_depth - ADDR_W'(1)));

  always_comb begin
    unique case (r_mode)
      2'd1:    w_hit = w_rise && !r_first;
      2'd2:    w_hit = w_fall && !r_first;
      default: w_hit = 1'b1;
    endcase
  end

  // Next-state and write sequencing
  always_comb begin
    w_state_nxt  = r_state;
    w_wr_fire    = 1'b0;
    w_done_nxt   = 1'b0;
    w_forced_nxt = r_forced;
    w_first_nxt  = r_first;
    w_addr_nxt   = r_addr;
    w_tcnt_nxt   = r_tcnt;

    unique case (r_state)
      S_IDLE: begin
        if (w_start_acc) begin
          w_state_nxt  = S_ARM;
          w_forced_nxt = 1'b0;
          w_first_nxt  = 1'b1;
          w_addr_nxt   = '0;
          w_tcnt_nxt   = '0;
        end
      end
      S_ARM: begin
        if (w_s_stb) begin
          w_first_nxt = 1'b0;
          w_tcnt_nxt  = w_tcnt_inc;
          if (w_hit || w_tmo_hit) begin
            // Triggering sample is written as sample 0 of the block
            w_wr_fire    = 1'b1;
            w_forced_nxt = !w_hit;
            w_addr_nxt   = r_addr + ADDR_W'(1);
            w_state_nxt  = w_last ? S_DONE : S_CAPTURE;
          end
        end
      end
      S_CAPTURE: begin
        if (w_s_stb) begin
          w_wr_fire   = 1'b1;
          w_addr_nxt  = r_addr + ADDR_W'(1);
          w_state_nxt = w_last ? S_DONE : S_CAPTURE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_done_nxt  = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (abort) begin
      w_state_nxt = S_IDLE;
      w_wr_fire   = 1'b0;
      w_done_nxt  = 1'b0;
      w_addr_nxt  = '0;
      w_tcnt_nxt  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Sample capture, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur     <= '0;
      r_addr    <= '0;
      r_tcnt    <= '0;
      r_first   <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_forced  <= 1'b0;
    end else begin
      if (w_s_stb) begin
        r_cur <= adc_data_s;
      end
      r_addr   <= w_addr_nxt;
      r_tcnt   <= w_tcnt_nxt;
      r_first  <= w_first_nxt;
      r_wr_en  <= w_wr_fire;
      if (w_wr_fire) begin
        r_wr_addr <= r_addr;
        r_wr_data <= adc_data_s;
      end
      // DONE is the last busy cycle so busy falls together with the done pulse
      r_busy   <= (w_state_nxt != S_IDLE);
      r_done   <= w_done_nxt;
      r_forced <= w_forced_nxt;
    end
  end

  assign adc_clk = r_adc_clk;
  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign busy    = r_busy;
  assign done    = r_done;
  assign forced  = r_forced;

endmodule
